// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_scan_ctrl_pkg
//   Shared definitions for the 4-digit seven-segment scan controller:
//   scan state encoding, logical "off" levels for anodes and segments,
//   the 16-entry hex glyph table and the leading-zero helper.
//   All segment/anode values here are logical (1 = lit); pin polarity is
//   applied only at the output registers of the top level.

package seven_seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [3:0] AN_OFF  = 4'h0;

    // Glyphs {g,f,e,d,c,b,a}, entry 0 in the lowest slice:
    // 0 1 2 3 4 5 6 7 8 9 A b C d E F
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // A digit is a leading zero when it and every digit to its left are 0.
    // Digit 0 always shows so a value of zero still displays "0".
    function automatic logic is_leading_zero(input logic [15:0] value,
                                             input logic [1:0]  idx);
        logic result;
        result = 1'b0;
        case (idx)
            2'd3:    result = (value[15:12] == 4'h0);
            2'd2:    result = (value[15:8]  == 8'h00);
            2'd1:    result = (value[15:4]  == 12'h000);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if
//   Register-file side of the scan controller: live display value, decimal
//   points, per-digit enables, leading-zero blanking, scan enable and the
//   load/load_ack capture handshake.
//   master : register file (drives live values and load, sees load_ack)
//   slave  : scan controller (samples live values, pulses load_ack)

interface seven_seg_scan_ctrl_if;

    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic        load;
    logic        load_ack;

    modport master (
        output en, digits, dp, digit_en, lz_blank, load,
        input  load_ack
    );

    modport slave (
        input  en, digits, dp, digit_en, lz_blank, load,
        output load_ack
    );

endinterface

// File: rtl/mux_2x4.sv
// mux_2x4
//   Four-input, W-bit wide multiplexer with a 2-bit select.
//   Ports: d0..d3 (in, W) data inputs, sel (in, 2) select, y (out, W).

module mux_2x4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl_hex_to_seg.sv
// hex_to_seg
//   Combinational hex nibble to seven-segment glyph decode.
//   Ports: hex (in, 4) nibble value, seg (out, 7) logical segments
//   {g,f,e,d,c,b,a}, 1 = segment lit.

module hex_to_seg
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = GLYPH_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   Each digit owns a slot of DIV cycles; the first BLANK cycles of a slot
//   keep every anode off to stop ghosting. The displayed value lives in
//   shadow registers that are only refreshed at a frame boundary (or while
//   idle), so a value change never tears across a frame.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     bus          register-file side (en, live values, load/load_ack)
//     sel          current digit index
//     an           anode enables (active-low when AN_ACT_LO)
//     seg          segments {g,f,e,d,c,b,a} (active-low when SEG_ACT_LO)
//     dp_out       decimal point pin (polarity as seg)
//     frame_done   one-cycle pulse when the digit 3 slot ends

module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int DIV        = 100_000,
    parameter int BLANK      = 1_000,
    parameter bit SEG_ACT_LO = 1'b1,
    parameter bit AN_ACT_LO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_ctrl_if.slave  bus,
    output logic [1:0]            sel,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam scan_state_t   SLOT_START = (BLANK > 0) ? ST_BLANK : ST_SHOW;

    // XOR masks turning logical levels into pin levels.
    localparam logic [3:0] AN_MASK  = {4{AN_ACT_LO}};
    localparam logic [6:0] SEG_MASK = {7{SEG_ACT_LO}};
    localparam logic       DP_MASK  = SEG_ACT_LO;

    scan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sel_n;
    logic          wrap;
    logic          capture;

    logic [15:0]   sh_digits, sh_digits_n;
    logic [3:0]    sh_dp, sh_dp_n;
    logic [3:0]    sh_en, sh_en_n;
    logic          sh_lz, sh_lz_n;

    logic          lit_n;
    logic [3:0]    nibble_n;
    logic [6:0]    glyph_n;
    logic          load_ack_q;

    // Slot sequencing. cnt runs across the whole slot (blank part included)
    // so a slot is exactly DIV cycles regardless of BLANK.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        wrap    = 1'b0;
        if (!bus.en) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            sel_n   = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = SLOT_START;
                    cnt_n   = '0;
                    sel_n   = 2'd0;
                end
                ST_BLANK: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_n = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_n   = '0;
                        sel_n   = sel + 2'd1;
                        state_n = SLOT_START;
                        wrap    = (sel == 2'd3);
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    sel_n   = 2'd0;
                end
            endcase
        end
    end

    // Shadow capture happens at a frame wrap or at any edge spent in IDLE.
    // Outputs are built from the post-edge shadow so that with BLANK == 0
    // slot 0 already shows the freshly captured value.
    always_comb begin
        capture     = bus.load && ((state == ST_IDLE) || wrap);
        sh_digits_n = capture ? bus.digits   : sh_digits;
        sh_dp_n     = capture ? bus.dp       : sh_dp;
        sh_en_n     = capture ? bus.digit_en : sh_en;
        sh_lz_n     = capture ? bus.lz_blank : sh_lz;
        lit_n       = (state_n == ST_SHOW) && sh_en_n[sel_n] &&
                      !(sh_lz_n && is_leading_zero(sh_digits_n, sel_n));
    end

    mux_2x4 #(.W(4)) u_digit_mux (
        .d0  (sh_digits_n[3:0]),
        .d1  (sh_digits_n[7:4]),
        .d2  (sh_digits_n[11:8]),
        .d3  (sh_digits_n[15:12]),
        .sel (sel_n),
        .y   (nibble_n)
    );

    hex_to_seg u_decode (
        .hex (nibble_n),
        .seg (glyph_n)
    );

    // A dark digit (blank phase, disabled or leading zero) drives every pin
    // off, not just its anode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= 2'd0;
            sh_digits  <= 16'h0000;
            sh_dp      <= 4'h0;
            sh_en      <= 4'h0;
            sh_lz      <= 1'b0;
            an         <= AN_OFF ^ AN_MASK;
            seg        <= SEG_OFF ^ SEG_MASK;
            dp_out     <= DP_MASK;
            load_ack_q <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            sh_digits  <= sh_digits_n;
            sh_dp      <= sh_dp_n;
            sh_en      <= sh_en_n;
            sh_lz      <= sh_lz_n;
            an         <= (lit_n ? (4'b0001 << sel_n) : AN_OFF) ^ AN_MASK;
            seg        <= (lit_n ? glyph_n : SEG_OFF) ^ SEG_MASK;
            dp_out     <= (lit_n & sh_dp_n[sel_n]) ^ DP_MASK;
            load_ack_q <= capture;
            frame_done <= wrap;
        end
    end

    assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
//   Self-checking bench for seven_seg_scan_ctrl with DIV=8, BLANK=2 and
//   active-low anodes and segments. A position-in-frame model predicts
//   every output each cycle; directed scenarios add literal expectations.

module tb_seven_seg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_out;
    logic       frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    seven_seg_scan_ctrl_if bus();

    seven_seg_scan_ctrl #(
        .DIV        (DIV),
        .BLANK      (BLANK),
        .SEG_ACT_LO (1'b1),
        .AN_ACT_LO  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Standard active-high glyphs 0..F.
    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    bit          m_valid = 1'b0;
    bit          m_running;
    int          m_pos;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic        m_lz;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_ack;
    logic        exp_fd;
    logic        exp_lit;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] digits,
                                 input logic [3:0] dp, input logic [3:0] digit_en,
                                 input logic lz, input logic load);
        bus.en       = en;
        bus.digits   = digits;
        bus.dp       = dp;
        bus.digit_en = digit_en;
        bus.lz_blank = lz;
        bus.load     = load;
    endtask

    task automatic waitAck(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.load_ack !== 1'b1 && n < 2 * FRAME);
        if (bus.load_ack !== 1'b1) timeoutFail(name);
    endtask

    task automatic waitSelLit(input logic [1:0] s, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel === s && an !== 4'hF) && n < 2 * FRAME);
        if (!(sel === s && an !== 4'hF)) timeoutFail(name);
    endtask

    task automatic waitFrameDone(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 2 * FRAME);
        if (frame_done !== 1'b1) timeoutFail("frame_done wait");
    endtask

    // Model: a running scan is just a position 0..FRAME-1 within the frame;
    // slot = pos / DIV, and a digit is lit for offsets BLANK..DIV-1.
    always @(posedge clk) begin
        bit         wrap_now;
        bit         cap_now;
        int         slot;
        int         offset;
        logic [3:0] nib;
        if (!rst_n) begin
            m_running = 1'b0;
            m_pos     = 0;
            m_digits  = 16'h0;
            m_dp      = 4'h0;
            m_en      = 4'h0;
            m_lz      = 1'b0;
            exp_ack   = 1'b0;
            exp_fd    = 1'b0;
            m_valid   = 1'b1;
        end else begin
            wrap_now = m_running && bus.en && (m_pos == FRAME - 1);
            cap_now  = bus.load && (!m_running || wrap_now);
            exp_ack  = cap_now;
            exp_fd   = wrap_now;
            if (cap_now) begin
                m_digits = bus.digits;
                m_dp     = bus.dp;
                m_en     = bus.digit_en;
                m_lz     = bus.lz_blank;
            end
            if (!bus.en) begin
                m_running = 1'b0;
                m_pos     = 0;
            end else if (!m_running) begin
                m_running = 1'b1;
                m_pos     = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
        end
        slot    = m_pos / DIV;
        offset  = m_pos % DIV;
        nib     = 4'(m_digits >> (4 * slot));
        exp_lit = m_running && (offset >= BLANK) && m_en[slot] &&
                  !(m_lz && slot != 0 && (m_digits >> (4 * slot)) == 16'h0);
        exp_sel = 2'(slot);
        exp_an  = exp_lit ? ~(4'b0001 << slot) : 4'hF;
        exp_seg = exp_lit ? ~glyphs[nib] : 7'h7F;
        exp_dp  = exp_lit ? ~m_dp[slot] : 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model sel", 32'(sel), 32'(exp_sel));
            checkOutput("model an", 32'(an), 32'(exp_an));
            checkOutput("model load_ack", 32'(bus.load_ack), 32'(exp_ack));
            checkOutput("model frame_done", 32'(frame_done), 32'(exp_fd));
            if (exp_lit || !m_running) begin
                checkOutput("model seg", 32'(seg), 32'(exp_seg));
                checkOutput("model dp_out", 32'(dp_out), 32'(exp_dp));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int hi_low;
        int an0_low;
        int lit_cycles;

        // Reset held with en and load high.
        rst_n = 1'b0;
        applyStimulus(1'b1, 16'h1234, 4'h0, 4'hF, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("reset an", 32'(an), 32'hF);
        checkOutput("reset seg", 32'(seg), 32'h7F);
        checkOutput("reset dp_out", 32'(dp_out), 32'h1);
        checkOutput("reset sel", 32'(sel), 32'h0);
        checkOutput("reset load_ack", 32'(bus.load_ack), 32'h0);
        checkOutput("reset frame_done", 32'(frame_done), 32'h0);

        // Load 1234 from IDLE, then scan.
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle load_ack", 32'(bus.load_ack), 32'h1);
        checkOutput("slot0 blank0 an", 32'(an), 32'hF);
        applyStimulus(1'b1, 16'h1234, 4'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("load_ack drop", 32'(bus.load_ack), 32'h0);
        checkOutput("slot0 blank1 an", 32'(an), 32'hF);
        @(negedge clk);
        checkOutput("slot0 an", 32'(an), 32'b1110);
        checkOutput("slot0 seg", 32'(seg), 32'b0011001);
        waitSelLit(2'd1, "slot1 wait");
        checkOutput("slot1 an", 32'(an), 32'b1101);
        checkOutput("slot1 seg", 32'(seg), 32'b0110000);
        waitSelLit(2'd3, "slot3 wait");
        checkOutput("slot3 an", 32'(an), 32'b0111);
        waitFrameDone(n);
        waitFrameDone(n);
        checkOutput("frame period", 32'(n), 32'd32);

        // 0005 with leading-zero blanking and dp on digit 0.
        applyStimulus(1'b1, 16'h0005, 4'b0001, 4'hF, 1'b1, 1'b1);
        waitAck("lz load ack");
        applyStimulus(1'b1, 16'h0005, 4'b0001, 4'hF, 1'b1, 1'b0);
        hi_low  = 0;
        an0_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (an[3:1] != 3'b111) hi_low++;
            if (an[0] == 1'b0) begin
                an0_low++;
                checkOutput("lz digit0 seg", 32'(seg), 32'b0010010);
                checkOutput("lz digit0 dp_out", 32'(dp_out), 32'h0);
            end
            @(negedge clk);
        end
        checkOutput("lz upper lit cycles", 32'(hi_low), 32'd0);
        checkOutput("lz digit0 lit cycles", 32'(an0_low), 32'd6);

        // Show 1111, request 2222 mid-frame: swap only at the wrap.
        applyStimulus(1'b1, 16'h1111, 4'h0, 4'hF, 1'b0, 1'b1);
        waitAck("1111 load ack");
        applyStimulus(1'b1, 16'h1111, 4'h0, 4'hF, 1'b0, 1'b0);
        waitSelLit(2'd1, "mid-frame sel1");
        applyStimulus(1'b1, 16'h2222, 4'h0, 4'hF, 1'b0, 1'b1);
        waitSelLit(2'd2, "pending sel2");
        checkOutput("pending seg still 1", 32'(seg), 32'b1111001);
        checkOutput("pending no ack", 32'(bus.load_ack), 32'h0);
        waitAck("2222 load ack");
        checkOutput("ack on wrap frame_done", 32'(frame_done), 32'h1);
        checkOutput("ack on wrap sel", 32'(sel), 32'h0);
        applyStimulus(1'b1, 16'h2222, 4'h0, 4'hF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("new value an", 32'(an), 32'b1110);
        checkOutput("new value seg", 32'(seg), 32'b0100100);

        // Drop en mid-SHOW of digit 2, then restart from slot 0.
        waitSelLit(2'd2, "en drop sel2");
        applyStimulus(1'b0, 16'h2222, 4'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("en off an", 32'(an), 32'hF);
        checkOutput("en off sel", 32'(sel), 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 16'h2222, 4'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("restart blank0 an", 32'(an), 32'hF);
        checkOutput("restart blank0 sel", 32'(sel), 32'h0);
        @(negedge clk);
        checkOutput("restart blank1 an", 32'(an), 32'hF);
        @(negedge clk);
        checkOutput("restart show an", 32'(an), 32'b1110);
        checkOutput("restart show seg", 32'(seg), 32'b0100100);

        // Reset mid-frame with a load pending.
        waitSelLit(2'd1, "reset mid-frame");
        applyStimulus(1'b1, 16'h9999, 4'hF, 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset an", 32'(an), 32'hF);
        checkOutput("midreset seg", 32'(seg), 32'h7F);
        checkOutput("midreset dp_out", 32'(dp_out), 32'h1);
        checkOutput("midreset sel", 32'(sel), 32'h0);
        checkOutput("midreset load_ack", 32'(bus.load_ack), 32'h0);
        checkOutput("midreset frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h9999, 4'hF, 4'hF, 1'b0, 1'b0);
        lit_cycles = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            if (an != 4'hF) lit_cycles++;
        end
        checkOutput("cleared shadow dark", 32'(lit_cycles), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
